// File: rtl/program_sequencer.sv
// program_sequencer: fetch-stage PC with jump, relative branch and call/return via a return-address stack.
module program_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int OFF_W       = 6,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_en,
  input  logic                             i_jmp,
  input  logic                             i_br,
  input  logic                             i_call,
  input  logic                             i_ret,
  input  logic [ADDR_W-1:0]                i_target,
  input  logic [OFF_W-1:0]                 i_offset,
  output logic [ADDR_W-1:0]                o_pc_out,
  output logic [ADDR_W-1:0]                o_pc_next,
  output logic [$clog2(STACK_DEPTH+1)-1:0] o_sp_count,
  output logic                             o_stack_full,
  output logic                             o_stack_empty,
  output logic                             o_err_ovf,
  output logic                             o_err_udf
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  logic [ADDR_W-1:0] r_pc;
  logic [SP_W-1:0]   r_sp;
  logic              r_ovf;
  logic              r_udf;
  // Sized to the full pointer range so the pointer indexes it without truncation.
  logic [ADDR_W-1:0] r_stack [2**SP_W];
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_br;
  logic [ADDR_W-1:0] w_top;
  logic [SP_W-1:0]   w_sp_dec;
  logic              w_full;
  logic              w_empty;
  logic              w_do_ret;
  logic              w_do_call;
  logic              w_push;
  logic              w_pop;
  assign w_inc     = r_pc + ADDR_W'(1);
  assign w_br      = r_pc + ADDR_W'($signed(i_offset));
  assign w_full    = r_sp == SP_W'(STACK_DEPTH);
  assign w_empty   = r_sp == '0;
  assign w_sp_dec  = r_sp - SP_W'(1);
  assign w_top     = r_stack[w_sp_dec];
  assign w_do_ret  = i_en & i_ret;
  assign w_do_call = i_en & ~i_ret & i_call;
  assign w_push    = w_do_call & ~w_full;
  assign w_pop     = w_do_ret & ~w_empty;
  assign o_pc_next = !i_en  ? r_pc :
                     i_ret  ? (w_empty ? w_inc : w_top) :
                     i_call ? (w_full ? w_inc : i_target) :
                     i_jmp  ? i_target :
                     i_br   ? w_br : w_inc;
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pc  <= ADDR_W'(RESET_ADDR);
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_pc  <= o_pc_next;
      r_sp  <= w_push ? r_sp + SP_W'(1) : w_pop ? w_sp_dec : r_sp;
      r_ovf <= r_ovf | (w_do_call & w_full);
      r_udf <= r_udf | (w_do_ret & w_empty);
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst && w_push) r_stack[r_sp] <= w_inc;
  end
  assign o_pc_out      = r_pc;
  assign o_sp_count    = r_sp;
  assign o_stack_full  = w_full;
  assign o_stack_empty = w_empty;
  assign o_err_ovf     = r_ovf;
  assign o_err_udf     = r_udf;
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed stimulus, queue-based reference model checked every cycle plus literal pins.
module tb_program_sequencer;
  localparam int AW = 6;
  localparam int OW = 6;
  localparam int D  = 4;
  localparam int SW = $clog2(D + 1);
  localparam int M  = 1 << AW;
  logic clk = 0, rst = 0, en = 0, jmp = 0, br = 0, call = 0, ret = 0;
  logic [AW-1:0] target = '0;
  logic [OW-1:0] offset = '0;
  logic [AW-1:0] pc_out, pc_next;
  logic [SW-1:0] sp_count;
  logic stack_full, stack_empty, err_ovf, err_udf;
  int m_pc;
  int stk[$];
  bit m_ovf, m_udf, chk = 0;
  int n_cmp = 0, n_err = 0;

  program_sequencer #(.ADDR_W(AW), .OFF_W(OW), .STACK_DEPTH(D), .RESET_ADDR(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_jmp(jmp), .i_br(br), .i_call(call), .i_ret(ret),
    .i_target(target), .i_offset(offset), .o_pc_out(pc_out), .o_pc_next(pc_next),
    .o_sp_count(sp_count), .o_stack_full(stack_full), .o_stack_empty(stack_empty),
    .o_err_ovf(err_ovf), .o_err_udf(err_udf)
  );

  always #5 clk = ~clk;

  function automatic int model_next();
    if (!en) return m_pc;
    if (ret) return stk.size() > 0 ? stk[$] : (m_pc + 1) & (M - 1);
    if (call) return stk.size() < D ? int'(target) : (m_pc + 1) & (M - 1);
    if (jmp) return int'(target);
    if (br) return (m_pc + int'($signed(offset))) & (M - 1);
    return (m_pc + 1) & (M - 1);
  endfunction

  task automatic cmp(string nm, logic [31:0] act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int nx;
    if (!rst) begin
      m_pc = 0;
      stk.delete();
      m_ovf = 0;
      m_udf = 0;
    end else if (en) begin
      nx = model_next();
      if (ret) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else m_udf = 1;
      end else if (call) begin
        if (stk.size() < D) stk.push_back((m_pc + 1) & (M - 1));
        else m_ovf = 1;
      end
      m_pc = nx;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      cmp("pc_out", pc_out, m_pc);
      cmp("sp_count", sp_count, stk.size());
      cmp("stack_full", stack_full, int'(stk.size() == D));
      cmp("stack_empty", stack_empty, int'(stk.size() == 0));
      cmp("err_ovf", err_ovf, int'(m_ovf));
      cmp("err_udf", err_udf, int'(m_udf));
      if (rst) cmp("pc_next", pc_next, model_next());
    end
  end

  // r, e, jmp, br, call, ret, target, offset
  task automatic step(bit r, bit e, bit j, bit b, bit c, bit rt, int tg, int of);
    rst = r; en = e; jmp = j; br = b; call = c; ret = rt;
    target = AW'(tg);
    offset = OW'(of);
    @(posedge clk);
    #2;
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk = 1;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    cmp("lit_reset_pc", pc_out, 0);
    cmp("lit_reset_sp", sp_count, 0);
    cmp("lit_reset_empty", stack_empty, 1);
    for (int i = 1; i <= 65; i++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0);
      if (i == 63) cmp("lit_inc_63", pc_out, 63);
      if (i == 64) cmp("lit_wrap_0", pc_out, 0);
    end
    cmp("lit_inc_after_wrap", pc_out, 1);
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
    cmp("lit_pc_10", pc_out, 10);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0, 40, 0);
    cmp("lit_freeze_pc", pc_out, 10);
    cmp("lit_freeze_sp", sp_count, 0);
    step(1, 1, 1, 0, 0, 0, 5, 0);
    cmp("lit_jmp_5", pc_out, 5);
    step(1, 1, 0, 1, 0, 0, 0, -3);
    cmp("lit_br_m3", pc_out, 2);
    step(1, 1, 0, 1, 0, 0, 0, -3);
    cmp("lit_br_wrap", pc_out, 63);
    step(1, 1, 0, 1, 0, 0, 0, 31);
    cmp("lit_br_p31", pc_out, 30);
    step(1, 1, 1, 0, 0, 0, 3, 0);
    step(1, 1, 0, 0, 1, 0, 20, 0);
    cmp("lit_call1_pc", pc_out, 20);
    step(1, 1, 0, 0, 1, 0, 40, 0);
    cmp("lit_call2_sp", sp_count, 2);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    cmp("lit_ret1_pc", pc_out, 21);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    cmp("lit_ret2_pc", pc_out, 4);
    cmp("lit_ret2_sp", sp_count, 0);
    step(1, 1, 1, 0, 0, 0, 8, 0);
    for (int t = 9; t <= 12; t++) step(1, 1, 0, 0, 1, 0, t, 0);
    cmp("lit_full", stack_full, 1);
    step(1, 1, 0, 0, 1, 0, 50, 0);
    cmp("lit_ovf_pc", pc_out, 13);
    cmp("lit_ovf_flag", err_ovf, 1);
    cmp("lit_ovf_sp", sp_count, 4);
    for (int k = 12; k >= 9; k--) begin
      step(1, 1, 0, 0, 0, 1, 0, 0);
      cmp("lit_ovf_ret", pc_out, k);
    end
    step(1, 1, 1, 0, 0, 0, 7, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    cmp("lit_udf_pc", pc_out, 8);
    cmp("lit_udf_flag", err_udf, 1);
    step(1, 1, 1, 1, 0, 0, 33, 5);
    cmp("lit_jmp_over_br", pc_out, 33);
    step(1, 1, 1, 0, 1, 0, 9, 0);
    cmp("lit_call_over_jmp", pc_out, 9);
    cmp("lit_call_over_jmp_sp", sp_count, 1);
    step(1, 1, 0, 0, 1, 1, 50, 0);
    cmp("lit_ret_over_call", pc_out, 34);
    cmp("lit_ret_over_call_sp", sp_count, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    cmp("lit_rst_ovf_clear", err_ovf, 0);
    step(1, 1, 0, 0, 1, 0, 20, 0);
    step(1, 1, 0, 0, 1, 0, 30, 0);
    cmp("lit_mid_sp", sp_count, 2);
    step(0, 1, 0, 0, 1, 0, 40, 0);
    cmp("lit_mid_rst_pc", pc_out, 0);
    cmp("lit_mid_rst_sp", sp_count, 0);
    cmp("lit_mid_rst_empty", stack_empty, 1);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    cmp("lit_post_rst_udf", err_udf, 1);
    cmp("lit_post_rst_pc", pc_out, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/program_sequencer.md
# program_sequencer

Parametrised program counter for the microprocessor's fetch stage. Beyond sequential increment it supports absolute jump, signed relative branch, and subroutine call/return through an internal return-address stack. It drives the instruction-memory address each cycle and reports stack status and sticky error flags to the control unit.

## Interface
- ADDR_W, 6: PC width in bits; address space is 2^ADDR_W instructions.
- OFF_W, 6: width of the signed two's-complement branch offset.
- STACK_DEPTH, 4: number of return-address stack entries, minimum 1.
- RESET_ADDR, 0: value loaded into the PC at reset.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en  in  1  advance enable; when 0, all state holds.
- jmp  in  1  absolute jump request.
- br  in  1  relative branch request.
- call  in  1  subroutine call request.
- ret  in  1  subroutine return request.
- target  in  ADDR_W  absolute destination for jmp and call.
- offset  in  OFF_W  signed branch offset relative to the current PC.
- pc_out  out  ADDR_W  registered current PC.
- pc_next  out  ADDR_W  combinational value pc_out takes at the next edge.
- sp_count  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
- stack_full  out  1  sp_count == STACK_DEPTH.
- stack_empty  out  1  sp_count == 0.
- err_ovf  out  1  sticky flag: a call occurred while the stack was full.
- err_udf  out  1  sticky flag: a ret occurred while the stack was empty.

## Operation
- Reset (rst == 0 at the edge): pc_out = RESET_ADDR, sp_count = 0, err_ovf = 0, err_udf = 0. Stack contents are don't-care. Reset overrides all other inputs.
- en == 0: pc_out, the stack, sp_count and the error flags hold. pc_next = pc_out.
- en == 1: exactly one operation executes, chosen by fixed priority ret > call > jmp > br > increment. Lower-priority requests in the same cycle are ignored.
  - ret, stack not empty: pc_out ← top entry; sp_count decrements.
  - ret, stack empty: pc_out ← pc_out+1; err_udf set.
  - call, stack not full: push pc_out+1 onto the stack, then pc_out ← target; sp_count increments.
  - call, stack full: no push and stack unchanged; pc_out ← pc_out+1; err_ovf set.
  - jmp: pc_out ← target.
  - br: pc_out ← pc_out + sign_extend(offset), computed modulo 2^ADDR_W.
  - none of the above: pc_out ← pc_out+1.
- Arithmetic: all PC sums are truncated to ADDR_W bits, so they wrap silently. 2^ADDR_W−1 + 1 gives 0. The pushed return address wraps the same way.
- Stack: LIFO. Push writes the entry at index sp_count; pop reads the entry at index sp_count−1.
- Error flags: once set, they stay set until reset. Neither flag blocks further operation.
- stack_full, stack_empty and sp_count are derived from registered state only.

## Timing
- pc_out, sp_count and the flags are registered. The effect of an operation is visible one cycle after the edge that samples it.
- pc_next is combinational from the current inputs and state. It equals the pc_out value that follows the next edge (when rst == 1), so the instruction memory can use it for prefetch.
- Zero-cycle turnaround: a ret issued in the cycle right after a call returns the address that call pushed.
- Reset deasserted: the first advance occurs on the first edge with rst == 1 and en == 1.
- Reset mid-call or mid-return sequence: the stack empties immediately and the flags clear. No partial push or pop survives.
- Multiple requests in one cycle (e.g. call and ret together): only the highest-priority request acts. A ret in that cycle does not also push.

## Test plan
- Reset and increment (ADDR_W=6): hold rst=0 for 2 cycles, then rst=1, en=1 for 65 cycles -> pc_out is 0 after reset, counts 1..63, then wraps to 0. Setting en=0 at pc_out=10 freezes it at 10.
- Branch: at pc_out=5, br=1, offset=−3 -> pc_out=2. Next cycle, br=1, offset=−3 -> pc_out=63 (wrap). Then offset=+31 -> pc_out=30.
- Call/return nesting (STACK_DEPTH=4): at pc 3, call target=20; at pc 20, call target=40; then ret, ret -> pc sequence 3, 20, 40, 21, 4. sp_count goes 0, 1, 2, 1, 0.
- Overflow: perform 4 calls so that stack_full=1, then call target=50 from pc 12 -> pc_out=13, err_ovf=1, sp_count stays 4. Then 4 rets return the 4 pushed addresses in reverse order.
- Underflow and priority: with the stack empty, ret at pc 7 -> pc_out=8, err_udf=1. With jmp=1, br=1, target=33, offset=5 at pc 8 -> pc_out=33. With call=1, jmp=1, target=9 -> push occurs, pc_out=9.
- Reset mid-operation: after 2 calls with err_ovf=0, assert rst=0 for 1 cycle -> pc_out=RESET_ADDR, sp_count=0, stack_empty=1. A subsequent ret sets err_udf=1.
